iccm_loader: RTL and testbench
==============================

Name: iccm_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction memory (iccm) write port.
- Accepts a byte stream, for example from a UART receiver. It first takes a 32-bit word count N, then N little-endian instruction words, and writes each word into iccm.
- Holds the core in reset until loading completes. Once loading is done it releases the core and stops driving iccm writes.

Parameters:
- DataWidth, 32, iccm word width; fixed at 32 (4 bytes per word).
- AddrWidth, 15, iccm byte-address width.
- MaxWords, 2**(AddrWidth-2), iccm capacity in words; a count above this is an error.

Ports:
- brq_clk  input  1  system clock; all state changes on the rising edge.
- brq_rst  input  1  asynchronous, active-low reset.
- load_start  input  1  single-cycle pulse; restarts a load from DONE or ERROR, ignored elsewhere.
- byte_valid  input  1  upstream byte is valid.
- byte_data  input  8  upstream byte.
- byte_ready  output  1  loader can accept a byte.
- iccm_write_en  output  1  iccm write strobe, one cycle per word.
- iccm_addr  output  AddrWidth  iccm byte address (word i is written at i<<2).
- iccm_wdata  output  DataWidth  assembled instruction word.
- core_hold  output  1  high keeps the core in reset.
- load_done  output  1  level; high in DONE.
- load_error  output  1  level; high in ERROR.

Behaviour:
- Transfer rule: a byte moves when byte_valid && byte_ready on a rising edge. byte_data is don't-care when byte_valid is low.
- Reset (brq_rst=0, asynchronous):
  - State goes to LEN with byte counter=0, word index=0 and shift register=0.
  - Outputs: byte_ready=1, iccm_write_en=0, iccm_addr=0, iccm_wdata=0, core_hold=1, load_done=0, load_error=0.
- Byte assembly is little-endian: byte k (k=0..3) of a group fills bits [8k+7:8k]. A 2-bit byte counter wraps 3→0 when a group completes.
- LEN state: collects 4 bytes into N. On the 4th accepted byte:
  - N==0 → DONE.
  - N>MaxWords → ERROR.
  - Otherwise → DATA, with word index=0.
- DATA state: collects 4 bytes. On the 4th accepted byte (cycle t) → WRITE.
- WRITE state (cycle t+1; exactly one cycle):
  - Outputs: iccm_write_en=1, iccm_addr=index<<2, iccm_wdata=assembled word, byte_ready=0.
  - Next: index+1 → if (index+1)==N then DONE, else DATA.
- Latency: from the 4th byte of a word being accepted to the write strobe is 1 cycle. Sustained throughput is 4 bytes per 5 cycles.
- DONE state: byte_ready=0, core_hold=0, load_done=1. Incoming bytes are not accepted.
- ERROR state: byte_ready=0, core_hold=1, load_error=1.
- load_start in DONE or ERROR: next cycle the loader is in LEN with counters cleared and core_hold=1. In all other states load_start is ignored.
- iccm_write_en is 0 in every state except WRITE. iccm_addr and iccm_wdata hold their last values outside WRITE.
- Gaps: byte_valid dropping mid-group leaves the partial group intact. There is no timeout.
- Boundary N==MaxWords: accepted. The last write lands at (MaxWords-1)<<2. Index arithmetic is AddrWidth-2+1 bits wide so it does not wrap before the compare.
- Reset asserted mid-load: aborts immediately with no further write strobes. Partially written iccm contents are left as-is.

Test Plan:
- Reset then stream 02 00 00 00, 13 05 10 00, 93 05 20 00 → two write strobes: addr 0x0000 data 0x00100513, then addr 0x0004 data 0x00200593. Each strobe is one cycle after its 4th byte, with byte_ready=0 that cycle. load_done=1 and core_hold=0 one cycle after the second write.
- Count 00 00 00 00 → no writes; DONE and core_hold=0 the cycle after the 4th byte.
- Count MaxWords+1 (0x00002001 for AddrWidth=15) → ERROR, load_error=1, core_hold=1, byte_ready=0, no writes. Then pulse load_start → back in LEN, load_error=0, byte_ready=1.
- One-word load with byte_valid deasserted for 7 cycles between bytes 2 and 3 of the word → the single write carries the correct word 0xDEADBEEF from bytes EF BE AD DE.
- Assert brq_rst asynchronously mid-load (between clock edges, after 1 of 3 words) → outputs return to reset values immediately with no further iccm_write_en. A fresh 1-word load then writes to addr 0x0000.
- Load of MaxWords words → final write at addr 0x7FFC and load_done=1. load_start pulsed during DATA has no effect.

Source files
------------

// File: rtl/iccm_loader.sv
// Boot-time ICCM loader: takes a little-endian 32-bit word count followed by that many
// instruction words from a byte stream, writes them into ICCM, then releases the core.
module iccm_loader #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 15,
    parameter int unsigned MaxWords  = 2 ** (AddrWidth - 2)
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 load_start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 iccm_write_en,
    output logic [AddrWidth-1:0] iccm_addr,
    output logic [DataWidth-1:0] iccm_wdata,
    output logic                 core_hold,
    output logic                 load_done,
    output logic                 load_error
);

    // One extra bit so that index+1 can reach MaxWords without wrapping before the compare.
    localparam int unsigned IdxWidth = AddrWidth - 1;

    typedef enum logic [2:0] {
        StLen,
        StData,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [IdxWidth-1:0]    word_idx_q, word_idx_d;
    logic [DataWidth-1:0]   shift_q, shift_d;
    logic [DataWidth-1:0]   word_cnt_q, word_cnt_d;

    logic                   ready_q, ready_d;
    logic                   wr_en_q, wr_en_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic                   hold_q, hold_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   byte_fire;
    logic                   group_done;
    logic [DataWidth-1:0]   group_word;
    logic [IdxWidth-1:0]    idx_inc;

    always_comb begin
        byte_fire  = byte_valid && ready_q;
        group_done = byte_fire && (byte_cnt_q == 2'd3);
        // Word as it stands once the current byte is merged into its lane.
        group_word = shift_q;
        group_word[{byte_cnt_q, 3'b000} +: 8] = byte_data;
        idx_inc    = word_idx_q + IdxWidth'(1);
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        shift_d    = shift_q;
        word_cnt_d = word_cnt_q;
        ready_d    = ready_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;

        unique case (state_q)
            StLen: begin
                if (byte_fire) begin
                    shift_d    = group_word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                if (group_done) begin
                    word_cnt_d = group_word;
                    word_idx_d = '0;
                    if (group_word == '0) begin
                        state_d = StDone;
                        ready_d = 1'b0;
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (group_word > DataWidth'(MaxWords)) begin
                        state_d = StError;
                        ready_d = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end

            StData: begin
                if (byte_fire) begin
                    shift_d    = group_word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                if (group_done) begin
                    state_d = StWrite;
                    ready_d = 1'b0;
                    wr_en_d = 1'b1;
                    addr_d  = {word_idx_q[IdxWidth-2:0], 2'b00};
                    wdata_d = group_word;
                end
            end

            StWrite: begin
                word_idx_d = idx_inc;
                if (DataWidth'(idx_inc) == word_cnt_q) begin
                    state_d = StDone;
                    hold_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = StData;
                    ready_d = 1'b1;
                end
            end

            StDone, StError: begin
                // Restart keeps the last address/data visible; only counters are cleared.
                if (load_start) begin
                    state_d    = StLen;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    shift_d    = '0;
                    ready_d    = 1'b1;
                    hold_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end

            default: begin
                state_d = StLen;
                ready_d = 1'b1;
                hold_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            state_q    <= StLen;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            shift_q    <= '0;
            word_cnt_q <= '0;
            ready_q    <= 1'b1;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            shift_q    <= shift_d;
            word_cnt_q <= word_cnt_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign byte_ready    = ready_q;
    assign iccm_write_en = wr_en_q;
    assign iccm_addr     = addr_q;
    assign iccm_wdata    = wdata_q;
    assign core_hold     = hold_q;
    assign load_done     = done_q;
    assign load_error    = err_q;

endmodule

// File: tb/tb_iccm_loader.sv
// Directed bench for iccm_loader: a vector table for the cycle-by-cycle cases, then
// hand-written sequences for async reset mid-load and a full-capacity load.
module tb_iccm_loader;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 2 ** (AW - 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load_start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          iccm_write_en;
    logic [AW-1:0] iccm_addr;
    logic [DW-1:0] iccm_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_error;

    iccm_loader #(
        .DataWidth(DW),
        .AddrWidth(AW)
    ) dut (
        .brq_clk      (clk),
        .brq_rst      (rst_n),
        .load_start   (load_start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .iccm_write_en(iccm_write_en),
        .iccm_addr    (iccm_addr),
        .iccm_wdata   (iccm_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [7:0]    data;
        logic          start;
        logic          rdy;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          hold;
        logic          done;
        logic          err;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic v, input logic [7:0] d, input logic s, input logic rdy,
                       input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic h, input logic dn, input logic er);
        vec_t t;
        t.valid = v; t.data = d; t.start = s; t.rdy = rdy; t.we = we;
        t.addr = a; t.wdata = wd; t.hold = h; t.done = dn; t.err = er;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic rdy, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic h, input logic dn, input logic er);
        n_tests++;
        if ({byte_ready, iccm_write_en, iccm_addr, iccm_wdata, core_hold, load_done, load_error}
            !== {rdy, we, a, wd, h, dn, er}) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b; want rdy=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b",
                     name, byte_ready, iccm_write_en, iccm_addr, iccm_wdata, core_hold,
                     load_done, load_error, rdy, we, a, wd, h, dn, er);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic s);
        @(negedge clk);
        byte_valid = v;
        byte_data  = d;
        load_start = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [DW-1:0] W0 = 32'h0010_0513;
    localparam logic [DW-1:0] W1 = 32'h0020_0593;
    localparam logic [DW-1:0] WB = 32'hDEAD_BEEF;

    initial begin
        logic [DW-1:0] word;
        logic [DW-1:0] last_word;

        #2 rst_n = 1'b0;
        #1 check("reset", 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Two-word load; a byte offered during WRITE must not be taken.
        add(1, 8'h02, 0, 1, 0, 15'h0, 32'h0, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 15'h0, 32'h0, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 15'h0, 32'h0, 1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 15'h0, 32'h0, 1, 0, 0);
        add(1, 8'h13, 0, 1, 0, 15'h0, 32'h0, 1, 0, 0);
        add(1, 8'h05, 0, 1, 0, 15'h0, 32'h0, 1, 0, 0);
        add(1, 8'h10, 0, 1, 0, 15'h0, 32'h0, 1, 0, 0);
        add(1, 8'h00, 0, 0, 1, 15'h0, W0,    1, 0, 0);
        add(1, 8'h93, 0, 1, 0, 15'h0, W0,    1, 0, 0);
        add(1, 8'h93, 0, 1, 0, 15'h0, W0,    1, 0, 0);
        add(1, 8'h05, 0, 1, 0, 15'h0, W0,    1, 0, 0);
        add(1, 8'h20, 0, 1, 0, 15'h0, W0,    1, 0, 0);
        add(1, 8'h00, 0, 0, 1, 15'h4, W1,    1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 15'h4, W1,    0, 1, 0);
        add(1, 8'hAA, 0, 0, 0, 15'h4, W1,    0, 1, 0);
        add(0, 8'h00, 1, 1, 0, 15'h4, W1,    1, 0, 0);
        // Zero count goes straight to DONE.
        add(1, 8'h00, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'h00, 0, 0, 0, 15'h4, W1,    0, 1, 0);
        add(0, 8'h00, 1, 1, 0, 15'h4, W1,    1, 0, 0);
        // Count MaxWords+1 -> ERROR, bytes refused, restart.
        add(1, 8'h01, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'h20, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'h00, 0, 0, 0, 15'h4, W1,    1, 0, 1);
        add(1, 8'h55, 0, 0, 0, 15'h4, W1,    1, 0, 1);
        add(0, 8'h00, 1, 1, 0, 15'h4, W1,    1, 0, 0);
        // One word with a 7-cycle gap; load_start in LEN is ignored.
        add(1, 8'h01, 1, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'h00, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'hEF, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'hBE, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        for (int g = 0; g < 7; g++) add(0, 8'h55, 0, 1, 0, 15'h4, W1, 1, 0, 0);
        add(1, 8'hAD, 0, 1, 0, 15'h4, W1,    1, 0, 0);
        add(1, 8'hDE, 0, 0, 1, 15'h0, WB,    1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 15'h0, WB,    0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].valid, vecs[i].data, vecs[i].start);
            check($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].addr,
                  vecs[i].wdata, vecs[i].hold, vecs[i].done, vecs[i].err);
        end

        // Async reset mid-load, with the 4th byte of word 1 on the bus.
        step(0, 8'h00, 1);
        check("rst_restart", 1, 0, 15'h0, WB, 1, 0, 0);
        step(1, 8'h03, 0); step(1, 8'h00, 0); step(1, 8'h00, 0); step(1, 8'h00, 0);
        step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
        check("rst_wr0", 0, 1, 15'h0, 32'h4433_2211, 1, 0, 0);
        step(0, 8'h00, 0);
        step(1, 8'h55, 0); step(1, 8'h66, 0); step(1, 8'h77, 0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h88;
        #2 rst_n = 1'b0;
        #1 check("rst_async", 1, 0, 15'h0, 32'h0, 1, 0, 0);
        @(posedge clk);
        #1 check("rst_no_write", 1, 0, 15'h0, 32'h0, 1, 0, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst_n      = 1'b1;
        step(1, 8'h01, 0); step(1, 8'h00, 0); step(1, 8'h00, 0); step(1, 8'h00, 0);
        step(1, 8'hAB, 0); step(1, 8'hCD, 0); step(1, 8'hEF, 0); step(1, 8'h01, 0);
        check("rst_fresh_wr", 0, 1, 15'h0, 32'h01EF_CDAB, 1, 0, 0);
        step(0, 8'h00, 0);
        check("rst_fresh_done", 0, 0, 15'h0, 32'h01EF_CDAB, 0, 1, 0);

        // Full-capacity load; load_start pulsed during DATA of word 5.
        step(0, 8'h00, 1);
        step(1, 8'h00, 0); step(1, 8'h20, 0); step(1, 8'h00, 0); step(1, 8'h00, 0);
        check("max_count", 1, 0, 15'h0, 32'h01EF_CDAB, 1, 0, 0);
        last_word = '0;
        for (int w = 0; w < int'(MW); w++) begin
            word = {w[15:0], w[15:0] ^ 16'hA5A5};
            step(1, word[7:0], 0);
            step(1, word[15:8], (w == 5));
            step(1, word[23:16], 0);
            step(1, word[31:24], 0);
            check($sformatf("max_wr%0d", w), 0, 1, AW'(w * 4), word, 1, 0, 0);
            last_word = word;
            step(0, 8'h00, 0);
        end
        check("max_done", 0, 0, 15'h7FFC, last_word, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
